// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush handling: holds, inserts bubbles or captures
// upstream payload, and keeps saturating counts of bubbles and hold cycles.
module pipe_stage_reg #(
    parameter int               WIDTH     = 48,
    parameter int               STAGE     = 2,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             held,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] hold_cnt
);

    logic             w_stall_here;
    logic             w_stall_next;
    logic             w_bubble;
    logic             w_hold;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_held;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_hold_cnt;

    assign w_stall_here = stall[STAGE];
    assign w_stall_next = stall[STAGE+1];
    // Flush outranks both stall outcomes, so neither is counted during a flush.
    assign w_bubble     = !flush &&  w_stall_here && !w_stall_next;
    assign w_hold       = !flush &&  w_stall_here &&  w_stall_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= NOP_VALUE;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else if (flush || w_bubble) begin
            r_data  <= NOP_VALUE;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else if (w_hold) begin
            r_held  <= 1'b1;
        end else begin
            r_data  <= in_valid ? in_data : NOP_VALUE;
            r_valid <= in_valid;
            r_held  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            if (w_hold && (r_hold_cnt != '1)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign held       = r_held;
    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model on two parameterisations.
module tb_pipe_stage_reg;

    localparam logic [47:0] NOP_A = 48'h0000_DEAD_BEEF;
    localparam int          S     = 2;

    logic        clk = 1'b0;
    logic        rst, flush, cnt_clr, in_valid;
    logic [5:0]  stall;
    logic [47:0] in_data;

    logic [47:0] a_data;
    logic        a_valid, a_held;
    logic [15:0] a_bcnt, a_hcnt;
    logic [47:0] b_data;
    logic        b_valid, b_held;
    logic [1:0]  b_bcnt, b_hcnt;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] m_data_a, m_data_b;
    logic        m_valid, m_held;
    int          m_bcnt_a, m_hcnt_a, m_bcnt_b, m_hcnt_b;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(48), .STAGE(S), .NOP_VALUE(NOP_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(a_data), .out_valid(a_valid), .held(a_held),
        .bubble_cnt(a_bcnt), .hold_cnt(a_hcnt)
    );

    pipe_stage_reg #(.WIDTH(48), .STAGE(S), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(b_data), .out_valid(b_valid), .held(b_held),
        .bubble_cnt(b_bcnt), .hold_cnt(b_hcnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: decide the action from the priority list, then apply it.
    task automatic model_update();
        bit is_bubble, is_hold;
        is_bubble = !flush && stall[S] && !stall[S+1];
        is_hold   = !flush && stall[S] &&  stall[S+1];
        if (rst) begin
            m_data_a = NOP_A; m_data_b = '0; m_valid = 0; m_held = 0;
            m_bcnt_a = 0; m_hcnt_a = 0; m_bcnt_b = 0; m_hcnt_b = 0;
        end else begin
            if (flush || is_bubble) begin
                m_data_a = NOP_A; m_data_b = '0; m_valid = 0; m_held = 0;
            end else if (is_hold) begin
                m_held = 1;
            end else begin
                m_valid  = in_valid;
                m_held   = 0;
                m_data_a = in_valid ? in_data : NOP_A;
                m_data_b = in_valid ? in_data : 48'h0;
            end
            if (cnt_clr) begin
                m_bcnt_a = 0; m_hcnt_a = 0; m_bcnt_b = 0; m_hcnt_b = 0;
            end else begin
                if (is_bubble) begin
                    m_bcnt_a = (m_bcnt_a < 65535) ? m_bcnt_a + 1 : 65535;
                    m_bcnt_b = (m_bcnt_b < 3) ? m_bcnt_b + 1 : 3;
                end
                if (is_hold) begin
                    m_hcnt_a = (m_hcnt_a < 65535) ? m_hcnt_a + 1 : 65535;
                    m_hcnt_b = (m_hcnt_b < 3) ? m_hcnt_b + 1 : 3;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("a_data",  64'(a_data),  64'(m_data_a));
        check("a_valid", 64'(a_valid), 64'(m_valid));
        check("a_held",  64'(a_held),  64'(m_held));
        check("a_bcnt",  64'(a_bcnt),  64'(m_bcnt_a));
        check("a_hcnt",  64'(a_hcnt),  64'(m_hcnt_a));
        check("b_data",  64'(b_data),  64'(m_data_b));
        check("b_valid", 64'(b_valid), 64'(m_valid));
        check("b_held",  64'(b_held),  64'(m_held));
        check("b_bcnt",  64'(b_bcnt),  64'(m_bcnt_b));
        check("b_hcnt",  64'(b_hcnt),  64'(m_hcnt_b));
    endtask

    task automatic drive(input logic r, input logic [5:0] st, input logic fl, input logic cc,
                         input logic [47:0] d, input logic v);
        rst = r; stall = st; flush = fl; cnt_clr = cc; in_data = d; in_valid = v;
    endtask

    initial begin
        logic [47:0] pay_a;
        m_data_a = 'x; m_data_b = 'x; m_valid = 'x; m_held = 'x;
        m_bcnt_a = 0; m_hcnt_a = 0; m_bcnt_b = 0; m_hcnt_b = 0;
        drive(1, 6'b0, 0, 0, 48'h0, 0);
        step();
        check("rst_data", 64'(a_data), 64'(NOP_A));
        check("rst_valid", 64'(a_valid), 64'd0);

        drive(0, 6'b0, 0, 0, 48'h0000_1234_5678, 1);
        step();
        check("pass_data", 64'(a_data), 64'h0000_1234_5678);
        check("pass_valid", 64'(a_valid), 64'd1);
        check("pass_bcnt", 64'(a_bcnt), 64'd0);

        drive(0, 6'b000100, 0, 0, 48'h1111, 1);
        step();
        check("bub_data", 64'(a_data), 64'(NOP_A));
        check("bub_bcnt", 64'(a_bcnt), 64'd1);
        check("bub_hcnt", 64'(a_hcnt), 64'd0);

        pay_a = 48'hA5A5_0000_C3C3;
        drive(0, 6'b0, 0, 0, pay_a, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 6'b001100, 0, 0, 48'h2222 + 48'(i), 1);
            step();
            check("hold_data", 64'(a_data), 64'(pay_a));
            check("hold_held", 64'(a_held), 64'd1);
        end
        check("hold_cnt3", 64'(a_hcnt), 64'd3);
        drive(0, 6'b0, 0, 0, 48'h0BAD_F00D, 1);
        step();
        check("hold_release", 64'(a_data), 64'h0BAD_F00D);

        drive(0, 6'b000100, 1, 0, 48'h3333, 1);
        step();
        check("flush_valid", 64'(a_valid), 64'd0);
        check("flush_bcnt", 64'(a_bcnt), 64'd1);

        for (int i = 0; i < 5; i++) begin
            drive(0, 6'b000100, 0, 0, 48'h0, 0);
            step();
        end
        check("sat_bcnt", 64'(b_bcnt), 64'd3);
        drive(0, 6'b000100, 0, 1, 48'h0, 0);
        step();
        check("clr_bcnt", 64'(b_bcnt), 64'd0);

        drive(0, 6'b0, 0, 0, pay_a, 1);
        step();
        drive(0, 6'b001100, 0, 0, 48'h4444, 1);
        step();
        drive(1, 6'b001100, 0, 0, 48'h4444, 1);
        step();
        check("rmh_data", 64'(a_data), 64'(NOP_A));
        check("rmh_held", 64'(a_held), 64'd0);
        check("rmh_hcnt", 64'(a_hcnt), 64'd0);
        drive(0, 6'b0, 0, 0, 48'h5555_6666, 1);
        step();
        check("rmh_fresh", 64'(a_data), 64'h5555_6666);

        for (int i = 0; i < 600; i++) begin
            logic [5:0] st;
            st = 6'($urandom);
            if ($urandom_range(0, 2) == 0) st[S] = 1'b0;
            drive(($urandom_range(0, 39) == 0), st, ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 29) == 0), {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
                  1'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 48, payload width in bits (aluop 8 + alusel 3 + wd 5 + wreg 1 + spare, or any stage bundle).
REQ-002 SHALL have parameter STAGE, default 2, index of the upstream stage in the stall vector; legal range 0..4.
REQ-003 SHALL have parameter NOP_VALUE, default all-zero WIDTH bits, payload driven when a bubble is issued.
REQ-004 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-005 SHALL have port clk, input, 1, clock; rising edge active.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port stall, input, 6, pipeline stall vector; bit s = 1 halts stage s.
REQ-008 SHALL have port flush, input, 1, exception/branch flush of this stage.
REQ-009 SHALL have port cnt_clr, input, 1, synchronous clear of both counters.
REQ-010 SHALL have port in_data, input, WIDTH, payload from the upstream stage.
REQ-011 SHALL have port in_valid, input, 1, upstream payload valid.
REQ-012 SHALL have port out_data, output, WIDTH, registered payload to the downstream stage.
REQ-013 SHALL have port out_valid, output, 1, registered valid.
REQ-014 SHALL have port held, output, 1, high in the cycle after a hold-cycle update.
REQ-015 SHALL have port bubble_cnt, output, CNT_W, count of bubbles inserted.
REQ-016 SHALL have port hold_cnt, output, CNT_W, count of hold cycles.

Function
REQ-017 SHALL update all registers only on the rising edge of clk.
REQ-018 SHALL use the following per-cycle priority: rst > flush > bubble > hold > capture.
REQ-019 On flush=1, SHALL load out_data=NOP_VALUE, out_valid=0 and held=0, and SHALL NOT count a bubble.
REQ-020 Bubble condition is stall[STAGE]=1 and stall[STAGE+1]=0; it SHALL load out_data=NOP_VALUE, out_valid=0 and held=0, and increment bubble_cnt.
REQ-021 Hold condition is stall[STAGE]=1 and stall[STAGE+1]=1; it SHALL keep out_data and out_valid unchanged, set held=1, and increment hold_cnt.
REQ-022 Capture condition is stall[STAGE]=0; it SHALL load out_valid=in_valid, set held=0, and load out_data=in_data when in_valid=1, otherwise NOP_VALUE.
REQ-023 Capture SHALL ignore stall[STAGE+1]; the upstream stall controller guarantees stall monotonicity.
REQ-024 Latency SHALL be exactly one cycle from in_data to out_data when no stall is active.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-026 cnt_clr=1 SHALL zero both counters and SHALL take precedence over a same-cycle increment; the payload path is unaffected.
REQ-027 Stall bits other than STAGE and STAGE+1 SHALL have no effect.
REQ-028 The block SHALL contain no combinational path from input to output.

Reset
REQ-029 With rst=1 at a clock edge, SHALL set out_data=NOP_VALUE, out_valid=0, held=0, bubble_cnt=0 and hold_cnt=0, overriding flush, stall and cnt_clr.
REQ-030 Reset asserted mid-hold SHALL discard the held payload; the first capture after reset releases SHALL load fresh in_data.

Verification
REQ-031 SHALL cover pass-through: stall=0, in_data=0x0000_1234_5678, in_valid=1 -> out_data=0x0000_1234_5678 and out_valid=1 one cycle later; counters stay 0.
REQ-032 SHALL cover a bubble: stall=6'b000100 for 1 cycle (STAGE=2) -> out_data=NOP_VALUE, out_valid=0, bubble_cnt=1, hold_cnt=0.
REQ-033 SHALL cover a hold: load payload A, then stall=6'b001100 for 3 cycles -> out_data=A throughout, held=1, hold_cnt=3; stall=0 then loads the next in_data.
REQ-034 SHALL cover flush priority: flush=1 together with stall=6'b000100 -> out_valid=0, bubble_cnt unchanged.
REQ-035 SHALL cover saturation and clear: CNT_W=2 with 5 bubbles -> bubble_cnt=3; cnt_clr=1 together with a bubble -> bubble_cnt=0.
REQ-036 SHALL cover reset mid-hold: rst=1 for 1 cycle during a hold -> all outputs at reset values; next capture loads in_data.
